// File: rtl/and_16b.sv
// and_16b: 16-bit bitwise AND for a power-clocked datapath.
// A four-phase sequencer (IDLE, EVAL, HOLD, RECOVER) captures the operands,
// presents a & b only during HOLD, and returns the output to zero otherwise.
// The datapath is split into lanes that share the sequencer's strobes.

module and_16b_lane #(
  parameter int VEC_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cap,   // IDLE->EVAL edge: latch operands
  input  logic             eval,  // EVAL->HOLD edge: drive result
  input  logic             clr,   // HOLD->RECOVER edge: return to zero
  input  logic [VEC_W-1:0] a,
  input  logic [VEC_W-1:0] b,
  output logic [VEC_W-1:0] y
);

  typedef struct packed {
    logic [VEC_W-1:0] a;
    logic [VEC_W-1:0] b;
  } opnd_t;

  opnd_t opnd_q;

  // Operand latch: later input changes do not disturb the cycle in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   opnd_q <= '0;
    else if (cap) opnd_q <= '{a: a, b: b};
  end

  // Result register: carries a & b only through HOLD, zero otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     y <= '0;
    else if (eval)  y <= opnd_q.a & opnd_q.b;
    else if (clr)   y <= '0;
  end

endmodule

module and_16b (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic [15:0] in_a,
  input  logic [15:0] in_b,
  output logic [15:0] out,
  output logic        out_valid,
  output logic [1:0]  phase
);

  localparam int NUM_LANES = 4;
  localparam int VEC_W     = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    EVAL    = 2'd1,
    HOLD    = 2'd2,
    RECOVER = 2'd3
  } phase_t;

  phase_t state, state_nxt;
  logic   cap, eval, clr;

  logic [NUM_LANES-1:0][VEC_W-1:0] lane_a, lane_b, lane_y;

  assign lane_a = in_a;
  assign lane_b = in_b;

  // Phase register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next phase and per-edge lane strobes; en matters only in IDLE.
  always_comb begin
    state_nxt = state;
    cap       = 1'b0;
    eval      = 1'b0;
    clr       = 1'b0;
    unique case (state)
      IDLE: begin
        if (en) begin
          state_nxt = EVAL;
          cap       = 1'b1;
        end
      end
      EVAL: begin
        state_nxt = HOLD;
        eval      = 1'b1;
      end
      HOLD: begin
        state_nxt = RECOVER;
        clr       = 1'b1;
      end
      RECOVER: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Valid flag tracks HOLD, registered alongside the result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    out_valid <= 1'b0;
    else if (eval) out_valid <= 1'b1;
    else if (clr)  out_valid <= 1'b0;
  end

  for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
    and_16b_lane #(.VEC_W(VEC_W)) u_lane (
      .clk   (clk),
      .rst_n (rst_n),
      .cap   (cap),
      .eval  (eval),
      .clr   (clr),
      .a     (lane_a[l]),
      .b     (lane_b[l]),
      .y     (lane_y[l])
    );
  end

  assign out   = lane_y;
  assign phase = state;

endmodule

// File: tb/tb_and_16b.sv
// Directed bench for and_16b: truth table, mixed pattern, operand stability,
// enable gating, mid-HOLD reset and back-to-back operation.
module tb_and_16b;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic [15:0] in_a = '0;
  logic [15:0] in_b = '0;
  logic [15:0] out;
  logic        out_valid;
  logic [1:0]  phase;

  int n_chk  = 0;
  int n_fail = 0;

  and_16b dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .in_a      (in_a),
    .in_b      (in_b),
    .out       (out),
    .out_valid (out_valid),
    .phase     (phase)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one edge and sample 1ns later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_st(input string tag, input logic [1:0] ph,
                        input logic [15:0] o, input logic v);
    chk({tag, ".phase"}, {14'd0, phase}, {14'd0, ph});
    chk({tag, ".out"}, out, o);
    chk({tag, ".valid"}, {15'd0, out_valid}, {15'd0, v});
  endtask

  // One full cycle from IDLE; en dropped after capture.
  task automatic run_cycle(input string tag, input logic [15:0] a,
                           input logic [15:0] b, input logic [15:0] exp);
    en = 1'b1; in_a = a; in_b = b;
    step(); en = 1'b0;
    chk_st({tag, ".eval"}, 2'd1, 16'h0000, 1'b0);
    step(); chk_st({tag, ".hold"}, 2'd2, exp, 1'b1);
    step(); chk_st({tag, ".rec"},  2'd3, 16'h0000, 1'b0);
    step(); chk_st({tag, ".idle"}, 2'd0, 16'h0000, 1'b0);
  endtask

  logic [15:0] b2b_a [4] = '{16'h1111, 16'hF0F0, 16'h00FF, 16'hAAAA};
  logic [15:0] b2b_b [4] = '{16'hFFFF, 16'h3C3C, 16'h0F0F, 16'h5555};
  logic [15:0] b2b_y [4] = '{16'h1111, 16'h3030, 16'h000F, 16'h0000};

  initial begin
    // Reset state, sampled while reset is held across edges.
    #12;
    chk_st("reset", 2'd0, 16'h0000, 1'b0);
    @(negedge clk); rst_n = 1'b1;
    step(); chk_st("post_reset_idle", 2'd0, 16'h0000, 1'b0);

    // Truth table.
    run_cycle("tt00", 16'h0000, 16'h0000, 16'h0000);
    run_cycle("ttF0", 16'hFFFF, 16'h0000, 16'h0000);
    run_cycle("tt0F", 16'h0000, 16'hFFFF, 16'h0000);
    run_cycle("ttFF", 16'hFFFF, 16'hFFFF, 16'hFFFF);

    // Mixed pattern: phase sequence 0,1,2,3,0 checked inside.
    run_cycle("mix", 16'hA5A5, 16'h0FF0, 16'h05A0);

    // Operand stability: change inputs during EVAL.
    en = 1'b1; in_a = 16'hFFFF; in_b = 16'hFFFF;
    step(); en = 1'b0; in_a = 16'h0000;
    chk_st("stab.eval", 2'd1, 16'h0000, 1'b0);
    step(); chk_st("stab.hold", 2'd2, 16'hFFFF, 1'b1);
    step(); step();

    // Enable gating.
    en = 1'b0; in_a = 16'hFFFF; in_b = 16'hFFFF;
    for (int i = 0; i < 5; i++) begin
      step(); chk_st("gate.low", 2'd0, 16'h0000, 1'b0);
    end
    en = 1'b1;
    step(); chk_st("gate.eval", 2'd1, 16'h0000, 1'b0);
    step(); chk_st("gate.hold", 2'd2, 16'hFFFF, 1'b1);
    en = 1'b0;
    step(); chk_st("gate.rec", 2'd3, 16'h0000, 1'b0);
    step(); chk_st("gate.idle", 2'd0, 16'h0000, 1'b0);
    step(); chk_st("gate.stay", 2'd0, 16'h0000, 1'b0);

    // Reset during HOLD.
    en = 1'b1; in_a = 16'hFFFF; in_b = 16'hFFFF;
    step(); en = 1'b0;
    step(); chk_st("rst.hold", 2'd2, 16'hFFFF, 1'b1);
    #2 rst_n = 1'b0;
    #1 chk_st("rst.async", 2'd0, 16'h0000, 1'b0);
    @(negedge clk); rst_n = 1'b1;
    run_cycle("rst.after", 16'h1234, 16'hFFFF, 16'h1234);

    // Back-to-back with en held high.
    en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_a = b2b_a[i]; in_b = b2b_b[i];
      step(); chk_st("b2b.eval", 2'd1, 16'h0000, 1'b0);
      in_a = 16'h0000; in_b = 16'h0000;
      step(); chk_st("b2b.hold", 2'd2, b2b_y[i], 1'b1);
      step(); chk_st("b2b.rec", 2'd3, 16'h0000, 1'b0);
      step(); chk_st("b2b.idle", 2'd0, 16'h0000, 1'b0);
    end
    en = 1'b0;
    step(); chk_st("b2b.end", 2'd0, 16'h0000, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
